multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Main control FSM for the multicycle MIPS datapath; sits directly upstream of `Alu_unit`, driving its 3-bit `control` port and the datapath mux selects, register/memory write enables and PC update. It decodes opcode/funct from the instruction register and steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states. It also keeps a retired-instruction counter for bench and debug use.

## Interface
- `CNT_W`, 32, width of the retired-instruction counter
- `clock`  in  1  single system clock, rising-edge
- `reset`  in  1  synchronous, active-high
- `opcode`  in  6  IR[31:26], stable from DECODE onward
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU zero flag, valid in BRANCH
- `pc_en`  out  1  PC load = pc_write | (pc_write_cond & zero)
- `i_or_d`  out  1  memory address: 0 = PC, 1 = ALUOut
- `mem_read`, `mem_write`, `ir_write`, `reg_write`  out  1 each
- `mem_to_reg`  out  1  write data: 0 = ALUOut, 1 = MDR
- `reg_dst`  out  1  dest: 0 = rt, 1 = rd
- `alu_src_a`  out  1  0 = PC, 1 = A
- `alu_src_b`  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `control`  out  3  to `Alu_unit`: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- `illegal`  out  1  one-cycle pulse on unsupported opcode/funct
- `state`  out  4  current state, debug
- `instr_count`  out  CNT_W  instructions retired

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11; 12–15 unreachable, go to FETCH.
- Outputs are Moore (from `state`) except `control` in EXEC (from `funct`) and `pc_en` (uses `zero`). All outputs not listed for a state are 0; `control` defaults to 010.
- FETCH: mem_read, ir_write, alu_src_b=01, pc_write -> DECODE.
- DECODE: alu_src_b=11 (branch target into ALUOut). Dispatch: lw 100011 / sw 101011 -> MEMADR; R-type 000000 -> EXEC; beq 000100 -> BRANCH; addi 001000 -> ADDIEX; j 000010 -> JUMP; anything else -> FETCH with `illegal`=1.
- R-type funct map: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; other funct -> `illegal` in DECODE, back to FETCH, no register write.
- MEMADR: alu_src_a=1, alu_src_b=10; -> MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_read, i_or_d -> MEMWB. MEMWB: reg_write, mem_to_reg -> FETCH.
- MEMWR: mem_write, i_or_d -> FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, control from funct -> ALUWB. ALUWB: reg_write, reg_dst -> FETCH.
- BRANCH: alu_src_a=1, control=110, pc_write_cond, pc_source=01 -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, control=010 -> ADDIWB. ADDIWB: reg_write (reg_dst=0) -> FETCH.
- JUMP: pc_write, pc_source=10 -> FETCH.
- `instr_count` increments by 1 on each transition into FETCH from a final state of a legal instruction (not on illegal, not out of reset); wraps modulo 2^CNT_W.

## Timing
- State register updates on rising `clock`; outputs change same cycle as state.
- While `reset`=1: state forced FETCH, `instr_count`=0, and every enable (`pc_en`, `mem_read`, `mem_write`, `ir_write`, `reg_write`, `illegal`) forced 0; selects and `control` read 0/010. First FETCH is the cycle after reset deasserts.
- Reset mid-instruction aborts it: no write enable asserts after the reset edge; count not incremented.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- `zero` sampled combinationally only in BRANCH; ignored elsewhere.

## Structure
- Package `mips_pkg`: state enum, opcode and funct constants, ALU control codes (shared with `Alu_unit`), `alu_src_b`/`pc_source` encodings.
- One sub-module: `alu_decoder` (combinational funct + ALUOp -> `control`, `funct_ok`); FSM and counter in the top.

## Test plan
- Reset held 3 cycles then released -> all enables 0 during reset, `state`=0, FETCH next cycle with mem_read=ir_write=pc_en=1, `control`=010.
- lw (opcode 100011) -> states 0,1,2,3,4,0; reg_write=mem_to_reg=1 only in MEMWB; `instr_count` 0->1.
- R-type funct 100010 then 101010 -> EXEC shows `control`=110 then 111; ALUWB reg_write=reg_dst=1; 4 cycles each.
- beq with zero=1 then zero=0 -> `pc_en`=1 in BRANCH only for zero=1; 3 cycles each.
- opcode 111111, then R-type funct 000111 -> `illegal` pulse in DECODE, return to FETCH, no write enables, count unchanged.
- reset asserted in MEMRD of lw -> no reg_write, `state`=0, `instr_count`=0 next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: FSM states, opcode and
// funct constants, ALU control codes and datapath mux encodings.
package mips_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11
    } state_e;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } aluop_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluSlt = 3'b111;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    // Last state of each legal instruction; leaving it retires the instruction.
    function automatic logic is_final(state_e s);
        return s inside {StMemWb, StMemWr, StAluWb, StBranch, StAddiWb, StJump};
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath signal bundle. master = controller, slave = datapath.
interface multicycle_controller_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             pc_en;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_source;
    logic [2:0]       control;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, funct, zero,
        output pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write, mem_to_reg,
               reg_dst, alu_src_a, alu_src_b, pc_source, control, illegal, state,
               instr_count
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write, mem_to_reg,
               reg_dst, alu_src_a, alu_src_b, pc_source, control, illegal, state,
               instr_count
    );
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from ALUOp and the R-type funct field.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    input  aluop_e     aluop,
    output logic [2:0] control,
    output logic       funct_ok
);
    logic [2:0] fn_control;

    always_comb begin
        fn_control = AluAdd;
        funct_ok   = 1'b1;
        case (funct)
            FnAdd:   fn_control = AluAdd;
            FnSub:   fn_control = AluSub;
            FnAnd:   fn_control = AluAnd;
            FnOr:    fn_control = AluOr;
            FnSlt:   fn_control = AluSlt;
            default: funct_ok   = 1'b0;
        endcase

        case (aluop)
            AluOpSub:   control = AluSub;
            AluOpFunct: control = fn_control;
            default:    control = AluAdd;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath, plus a retired-instruction
// counter. Outputs are gated low while reset is held.
module multicycle_controller
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input logic                     clock,
    input logic                     reset,
    multicycle_controller_if.master bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q;

    logic       pc_write, pc_write_cond;
    logic       i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic       mem_to_reg, reg_dst, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_source;
    aluop_e     aluop;
    logic [2:0] alu_control;
    logic       funct_ok;

    alu_decoder u_alu_decoder (
        .funct    (bus.funct),
        .aluop    (aluop),
        .control  (alu_control),
        .funct_ok (funct_ok)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StFetch;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (is_final(state_q)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SrcBReg;
        pc_source     = PcSrcAlu;
        aluop         = AluOpAdd;
        illegal       = 1'b0;

        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = SrcBFour;
                pc_write  = 1'b1;
                state_d   = StDecode;
            end
            StDecode: begin
                // Precompute the branch target into ALUOut while dispatching.
                alu_src_b = SrcBImmSh;
                case (bus.opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype: begin
                        if (funct_ok) begin
                            state_d = StExec;
                        end else begin
                            illegal = 1'b1;
                            state_d = StFetch;
                        end
                    end
                    OpBeq:   state_d = StBranch;
                    OpAddi:  state_d = StAddiEx;
                    OpJ:     state_d = StJump;
                    default: begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                state_d   = (bus.opcode == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_d  = StMemWb;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                state_d   = StFetch;
            end
            StExec: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBReg;
                aluop     = AluOpFunct;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                aluop         = AluOpSub;
                pc_write_cond = 1'b1;
                pc_source     = PcSrcAluOut;
                state_d       = StFetch;
            end
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                aluop     = AluOpAdd;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StJump: begin
                pc_write  = 1'b1;
                pc_source = PcSrcJump;
                state_d   = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    assign bus.pc_en       = !reset && (pc_write || (pc_write_cond && bus.zero));
    assign bus.i_or_d      = !reset && i_or_d;
    assign bus.mem_read    = !reset && mem_read;
    assign bus.mem_write   = !reset && mem_write;
    assign bus.ir_write    = !reset && ir_write;
    assign bus.reg_write   = !reset && reg_write;
    assign bus.mem_to_reg  = !reset && mem_to_reg;
    assign bus.reg_dst     = !reset && reg_dst;
    assign bus.alu_src_a   = !reset && alu_src_a;
    assign bus.alu_src_b   = reset ? SrcBReg : alu_src_b;
    assign bus.pc_source   = reset ? PcSrcAlu : pc_source;
    assign bus.control     = reset ? AluAdd : alu_control;
    assign bus.illegal     = !reset && illegal;
    assign bus.state       = reset ? 4'(StFetch) : 4'(state_q);
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-cycle vector table, reset corner cases, and random
// instruction streams checked against an instruction-level reference model.
module tb_multicycle_controller;
    logic clock;
    logic reset;

    multicycle_controller_if #(.CNT_W(32)) bus ();

    multicycle_controller #(.CNT_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output bundle order: pc_en i_or_d mem_read mem_write ir_write reg_write mem_to_reg
    // reg_dst alu_src_a alu_src_b[2] pc_source[2] control[3] illegal
    function automatic logic [16:0] o(input logic pe, input logic iod, input logic mr,
                                      input logic mw, input logic irw, input logic rw,
                                      input logic m2r, input logic rd, input logic sa,
                                      input logic [1:0] sb, input logic [1:0] ps,
                                      input logic [2:0] ctl, input logic ill);
        return {pe, iod, mr, mw, irw, rw, m2r, rd, sa, sb, ps, ctl, ill};
    endfunction

    function automatic logic [16:0] outs_now();
        return {bus.pc_en, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.reg_write, bus.mem_to_reg, bus.reg_dst, bus.alu_src_a, bus.alu_src_b,
                bus.pc_source, bus.control, bus.illegal};
    endfunction

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic [3:0]  st;
        logic [16:0] outs;
        int          cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                input logic [3:0] st, input logic [16:0] outs, input int cnt);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.st = st; v.outs = outs; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    // Instruction-level model: totals over one instruction, FETCH through last state.
    typedef struct {
        int cycles, rw, mw, mr, irw, pcen, ill, ret;
    } exp_t;

    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input logic z);
        exp_t e;
        logic fn_ok;
        fn_ok = (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100) ||
                (fn == 6'b100101) || (fn == 6'b101010);
        e = '{cycles: 2, rw: 0, mw: 0, mr: 1, irw: 1, pcen: 1, ill: 1, ret: 0};
        case (op)
            6'b100011: e = '{5, 1, 0, 2, 1, 1, 0, 1};
            6'b101011: e = '{4, 0, 1, 1, 1, 1, 0, 1};
            6'b000000: if (fn_ok) e = '{4, 1, 0, 1, 1, 1, 0, 1};
            6'b001000: e = '{4, 1, 0, 1, 1, 1, 0, 1};
            6'b000100: e = '{3, 0, 0, 1, 1, 1 + int'(z), 0, 1};
            6'b000010: e = '{3, 0, 0, 1, 1, 2, 0, 1};
            default: ;
        endcase
        return e;
    endfunction

    logic [16:0] f_o, d_o, dill_o, madr_o, mrd_o, mwb_o, mwr_o, exsub_o, exslt_o;
    logic [16:0] awb_o, br1_o, br0_o, aex_o, iwb_o, jmp_o;

    initial begin
        f_o     = o(1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
        d_o     = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0);
        dill_o  = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 1);
        madr_o  = o(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
        mrd_o   = o(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0);
        mwb_o   = o(0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 3'b010, 0);
        mwr_o   = o(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0);
        exsub_o = o(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b110, 0);
        exslt_o = o(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b111, 0);
        awb_o   = o(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0);
        br1_o   = o(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0);
        br0_o   = o(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0);
        aex_o   = o(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
        iwb_o   = o(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0);
        jmp_o   = o(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010, 0);

        // lw
        add(6'b100011, 6'b0, 0, 0, f_o, 0);     add(6'b100011, 6'b0, 0, 1, d_o, 0);
        add(6'b100011, 6'b0, 0, 2, madr_o, 0);  add(6'b100011, 6'b0, 0, 3, mrd_o, 0);
        add(6'b100011, 6'b0, 0, 4, mwb_o, 0);
        // R-type sub, then slt
        add(6'b000000, 6'b100010, 0, 0, f_o, 1);  add(6'b000000, 6'b100010, 0, 1, d_o, 1);
        add(6'b000000, 6'b100010, 0, 6, exsub_o, 1); add(6'b000000, 6'b100010, 0, 7, awb_o, 1);
        add(6'b000000, 6'b101010, 0, 0, f_o, 2);  add(6'b000000, 6'b101010, 0, 1, d_o, 2);
        add(6'b000000, 6'b101010, 0, 6, exslt_o, 2); add(6'b000000, 6'b101010, 0, 7, awb_o, 2);
        // beq taken, then not taken
        add(6'b000100, 6'b0, 1, 0, f_o, 3);  add(6'b000100, 6'b0, 1, 1, d_o, 3);
        add(6'b000100, 6'b0, 1, 8, br1_o, 3);
        add(6'b000100, 6'b0, 0, 0, f_o, 4);  add(6'b000100, 6'b0, 0, 1, d_o, 4);
        add(6'b000100, 6'b0, 0, 8, br0_o, 4);
        // illegal opcode, then illegal R-type funct
        add(6'b111111, 6'b0, 0, 0, f_o, 5);  add(6'b111111, 6'b0, 0, 1, dill_o, 5);
        add(6'b000000, 6'b000111, 0, 0, f_o, 5); add(6'b000000, 6'b000111, 0, 1, dill_o, 5);
        // sw, addi, j
        add(6'b101011, 6'b0, 0, 0, f_o, 5);  add(6'b101011, 6'b0, 0, 1, d_o, 5);
        add(6'b101011, 6'b0, 0, 2, madr_o, 5); add(6'b101011, 6'b0, 0, 5, mwr_o, 5);
        add(6'b001000, 6'b0, 0, 0, f_o, 6);  add(6'b001000, 6'b0, 0, 1, d_o, 6);
        add(6'b001000, 6'b0, 0, 9, aex_o, 6); add(6'b001000, 6'b0, 0, 10, iwb_o, 6);
        add(6'b000010, 6'b0, 1, 0, f_o, 7);  add(6'b000010, 6'b0, 1, 1, d_o, 7);
        add(6'b000010, 6'b0, 1, 11, jmp_o, 7);
        // lw started here is aborted by reset in MEMRD below
        add(6'b100011, 6'b0, 0, 0, f_o, 8);
    end

    initial begin
        exp_t        e;
        int          cyc, rw, mw, mr, irw, pcen, ill;
        logic [31:0] cnt0;
        logic [5:0]  op, fn;
        logic        z;

        reset      = 1'b1;
        bus.opcode = 6'b0;
        bus.funct  = 6'b0;
        bus.zero   = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            chk("rst_state", 32'(bus.state), 32'd0);
            chk("rst_outs", 32'(outs_now()), 32'(o(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00,
                                                    3'b010, 0)));
            chk("rst_count", bus.instr_count, 32'd0);
        end
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.opcode = vecs[i].op;
            bus.funct  = vecs[i].fn;
            bus.zero   = vecs[i].z;
            #1;
            chk($sformatf("vec%0d_state", i), 32'(bus.state), 32'(vecs[i].st));
            chk($sformatf("vec%0d_outs", i), 32'(outs_now()), 32'(vecs[i].outs));
            chk($sformatf("vec%0d_count", i), bus.instr_count, 32'(vecs[i].cnt));
            @(posedge clock);
            #1;
        end

        // Abort lw in MEMRD with reset.
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("abort_in_memrd", 32'(bus.state), 32'd3);
        reset = 1'b1;
        #1;
        chk("abort_rw_during", 32'(bus.reg_write), 32'd0);
        chk("abort_mr_during", 32'(bus.mem_read), 32'd0);
        @(posedge clock); #1;
        chk("abort_state", 32'(bus.state), 32'd0);
        chk("abort_rw_after", 32'(bus.reg_write), 32'd0);
        chk("abort_count", bus.instr_count, 32'd0);
        reset = 1'b0;
        #1;
        chk("abort_refetch", 32'(outs_now()), 32'(f_o));

        // Random instruction stream against the instruction-level model.
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 7))
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: op = 6'b000000;
                3: op = 6'b000100;
                4: op = 6'b001000;
                5: op = 6'b000010;
                default: op = 6'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: fn = 6'b100000;
                1: fn = 6'b100010;
                2: fn = 6'b100100;
                3: fn = 6'b100101;
                4: fn = 6'b101010;
                default: fn = 6'($urandom);
            endcase
            z = 1'($urandom);
            bus.opcode = op;
            bus.funct  = fn;
            bus.zero   = z;
            #1;
            e    = model(op, fn, z);
            cnt0 = bus.instr_count;
            cyc = 0; rw = 0; mw = 0; mr = 0; irw = 0; pcen = 0; ill = 0;
            do begin
                rw   += int'(bus.reg_write);
                mw   += int'(bus.mem_write);
                mr   += int'(bus.mem_read);
                irw  += int'(bus.ir_write);
                pcen += int'(bus.pc_en);
                ill  += int'(bus.illegal);
                @(posedge clock);
                #1;
                cyc++;
            end while (bus.state != 4'd0 && cyc < 10);
            chk("rnd_cycles", 32'(cyc), 32'(e.cycles));
            chk("rnd_reg_write", 32'(rw), 32'(e.rw));
            chk("rnd_mem_write", 32'(mw), 32'(e.mw));
            chk("rnd_mem_read", 32'(mr), 32'(e.mr));
            chk("rnd_ir_write", 32'(irw), 32'(e.irw));
            chk("rnd_pc_en", 32'(pcen), 32'(e.pcen));
            chk("rnd_illegal", 32'(ill), 32'(e.ill));
            chk("rnd_retire", bus.instr_count - cnt0, 32'(e.ret));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
